// File: rtl/fifo_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_port
// Brief    : FIFO read side: RAM read sequencing into a 2-entry output buffer
// Revision : 1.0
// ============================================================================
module fifo_rd_port #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW:0]   wr_ptr,
    output logic [AW:0]   rd_ptr,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          empty,
    output logic [AW+1:0] count,
    output logic          ovf_err
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    buf_state_t    state_q, state_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          infl_q, infl_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          ovf_q, ovf_d;

    logic [AW:0]   w_pending;
    logic [1:0]    w_occ;
    logic [2:0]    w_slots;
    logic          w_pop;
    logic          w_cap;
    logic          w_ren;

    always_comb begin
        w_occ = 2'd0;
        case (state_q)
            ST_ONE:  w_occ = 2'd1;
            ST_TWO:  w_occ = 2'd2;
            default: w_occ = 2'd0;
        endcase
    end

    assign w_pending = wr_ptr - rd_ptr_q;
    assign w_pop     = (state_q != ST_EMPTY) && dout_ready;
    // Buffer slots still claimed at the coming edge; pop is only possible when occ >= 1.
    assign w_slots   = {1'b0, w_occ} + {2'b00, infl_q} - {2'b00, w_pop};
    assign w_ren     = rst_n && (w_pending != '0) && !flush && (w_slots < 3'd2);
    assign w_cap     = infl_q && !flush;

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        infl_d   = w_ren;
        rd_ptr_d = w_ren ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q || (w_pending > c_DEPTH);

        case (state_q)
            ST_EMPTY: begin
                if (w_cap) begin
                    head_d  = ram_rdata;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_cap && w_pop) begin
                    head_d = ram_rdata;
                end else if (w_cap) begin
                    tail_d  = ram_rdata;
                    state_d = ST_TWO;
                end else if (w_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    head_d = tail_q;
                    if (w_cap) begin
                        tail_d = ram_rdata;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides everything except the sticky overflow flag.
        if (flush) begin
            state_d  = ST_EMPTY;
            infl_d   = 1'b0;
            rd_ptr_d = wr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= '0;
            infl_q   <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= infl_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign ram_ren    = w_ren;
    assign ram_raddr  = rd_ptr_q[AW-1:0];
    assign dout       = head_q;
    assign dout_valid = (state_q != ST_EMPTY);
    assign ovf_err    = ovf_q;
    assign count      = {1'b0, w_pending} + {{AW{1'b0}}, w_occ} + {{(AW+1){1'b0}}, infl_q};
    assign empty      = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_port
// Brief    : Directed + randomized self-checking bench for fifo_rd_port
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_port;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          flush;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          empty;
    logic [AW+1:0] count;
    logic          ovf_err;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    fifo_rd_port #(.DW(DW), .AW(AW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .ram_ren    (ram_ren),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .empty      (empty),
        .count      (count),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data one cycle after the enable.
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [DW-1:0] d);
        mem[wr_ptr[AW-1:0]] = d;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            reads;
        int            bad;
        int            idle;
        logic [AW:0]   pend;
        logic [DW-1:0] d;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_n = 1'b0; wr_ptr = 5'd3; flush = 1'b0; dout_ready = 1'b0;

        // Reset values, read enable suppressed even with data pending
        @(negedge clk); #1;
        chk("rst_ren", ram_ren, 0);
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ovf", ovf_err, 0);
        wr_ptr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_empty", empty, 1);
        chk("idle_count", count, 0);
        chk("idle_valid", dout_valid, 0);
        chk("idle_ren", ram_ren, 0);

        // Single word latency
        put(8'hA5); #1;
        chk("one_ren", ram_ren, 1);
        chk("one_raddr", ram_raddr, 0);
        tick();
        chk("one_ren_once", ram_ren, 0);
        chk("one_not_early", dout_valid, 0);
        tick();
        chk("one_valid", dout_valid, 1);
        chk("one_dout", dout, 8'hA5);
        chk("one_count", count, 1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        chk("one_drained", empty, 1);

        // Five words with a stalled consumer, then full-rate drain
        for (int i = 0; i < 5; i++) put(8'h10 + 8'(i));
        #1;
        reads = 0;
        repeat (6) begin
            if (ram_ren) reads++;
            tick();
        end
        chk("five_reads", reads, 2);
        chk("five_count", count, 5);
        chk("five_stable", dout, 8'h10);
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("five_valid", dout_valid, 1);
            chk("five_dout", dout, 8'h10 + 8'(i));
            tick();
        end
        dout_ready = 1'b0;
        chk("five_empty", empty, 1);
        chk("five_valid_end", dout_valid, 0);

        // Pointer wrap at 5'h0F -> 5'h10
        for (int i = 0; i < 9; i++) put(8'(i));
        dout_ready = 1'b1;
        repeat (12) tick();
        dout_ready = 1'b0;
        chk("wrap_pre_ptr", rd_ptr, 5'h0F);
        put(8'h3C); #1;
        chk("wrap_raddr", ram_raddr, 4'hF);
        chk("wrap_ren", ram_ren, 1);
        tick();
        chk("wrap_ptr", rd_ptr, 5'h10);
        tick();
        chk("wrap_dout", dout, 8'h3C);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;

        // Flush with a full buffer and a pop in the same cycle
        for (int i = 0; i < 4; i++) put(8'hE0 + 8'(i));
        repeat (4) tick();
        chk("fl_pre_count", count, 4);
        flush = 1'b1; dout_ready = 1'b1;
        tick();
        flush = 1'b0; dout_ready = 1'b0;
        chk("fl_valid", dout_valid, 0);
        chk("fl_ptr", rd_ptr, wr_ptr);
        chk("fl_count", count, 0);
        bad = 0;
        repeat (4) begin
            if (dout_valid || ram_ren) bad++;
            tick();
        end
        chk("fl_stale", bad, 0);

        // Flush while a RAM read is in flight
        put(8'hBB);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl2_count", count, 0);
        bad = 0;
        repeat (3) begin
            if (dout_valid) bad++;
            tick();
        end
        chk("fl2_stale", bad, 0);

        // Overflow: exactly depth is legal, one more sets the sticky flag
        wr_ptr = rd_ptr + 5'd16;
        tick();
        chk("ovf_at_depth", ovf_err, 0);
        wr_ptr = rd_ptr + 5'd17;
        tick();
        chk("ovf_set", ovf_err, 1);
        tick();
        chk("ovf_sticky", ovf_err, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("ovf_after_flush", ovf_err, 1);
        chk("ovf_flush_count", count, 0);

        // Asynchronous reset in the middle of a transfer
        put(8'h11); put(8'h22);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ovf", ovf_err, 0);
        chk("arst_ptr", rd_ptr, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_ren", ram_ren, 0);
        wr_ptr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_resume_empty", empty, 1);
        chk("arst_resume_ptr", rd_ptr, 0);

        // Randomized traffic against an ordered queue of unread words
        idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_count", count, q.size());
            chk("rnd_empty", empty, q.size() == 0);
            chk("rnd_ovf", ovf_err, 0);
            if (dout_valid) begin
                chk("rnd_valid_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("rnd_head", dout, q[0]);
            end
            if (q.size() != 0 && !dout_valid) idle++;
            else idle = 0;
            chk("rnd_stall", idle > 3, 0);

            dout_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 63) == 0);
            pend       = wr_ptr - rd_ptr;
            if (pend < 5'(DEPTH) && $urandom_range(0, 2) != 0) begin
                d = 8'($urandom);
                put(d);
                q.push_back(d);
            end
            if (dout_valid && dout_ready && q.size() != 0) void'(q.pop_front());
            if (flush) q.delete();
            tick();
        end
        flush = 1'b0;
        dout_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
